// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among NREQ requesters.
// Each access walks IDLE -> READ -> DATA -> RESP; every output is registered.
module rom_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              busy,
  output logic              rom_en,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StData, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   pick, cand;
  logic            found;

  logic [NREQ-1:0] gnt_d, rsp_valid_d;
  logic [DW-1:0]   rsp_data_d;
  logic            busy_d, rom_en_d;
  logic [AW-1:0]   rom_addr_d;

  // First requester at or above ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    busy_d      = 1'b1;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (found) begin
          state_d     = StRead;
          win_d       = pick;
          rom_addr_d  = req_addr[pick*AW +: AW];
          gnt_d[pick] = 1'b1;
          rom_en_d    = 1'b1;
          busy_d      = 1'b1;
        end
      end
      StRead: begin
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        state_d = StData;
      end
      StData: begin
        rsp_data_d         = rom_data;
        rsp_valid_d[win_q] = 1'b1;
        state_d            = StResp;
      end
      StResp: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      busy      <= busy_d;
      rom_en    <= rom_en_d;
      rom_addr  <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 8x8 ROM holding mem[a] = a.
module tb_rom_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;

  int n_assert = 0;
  int n_fail   = 0;

  rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // Output is poisoned when not enabled so a mistimed capture shows up.
  always @(posedge clk) rom_data <= rom_en ? {5'b0, rom_addr} : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic [DW-1:0] data);
    check({tag, " gnt"}, 32'(gnt), 32'h0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " rom_en"}, 32'(rom_en), 32'h0);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(data));
  endtask

  // Runs one full access from IDLE for requester k, dropping req[k] on its response.
  task automatic serve(input string tag, input int k, input logic [AW-1:0] addr);
    tick();
    check({tag, " gnt"}, 32'(gnt), 32'(1) << k);
    check({tag, " rom_en"}, 32'(rom_en), 32'h1);
    check({tag, " rom_addr"}, 32'(rom_addr), 32'(addr));
    check({tag, " busy read"}, 32'(busy), 32'h1);
    tick();
    check({tag, " rom_en data"}, 32'(rom_en), 32'h0);
    check({tag, " gnt data"}, 32'(gnt), 32'h0);
    tick();
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1) << k);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(addr));
    check({tag, " rom_addr resp"}, 32'(rom_addr), 32'(addr));
    req[k] = 1'b0;
    tick();
    check({tag, " rsp_valid idle"}, 32'(rsp_valid), 32'h0);
    check({tag, " busy idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    tick();
    tick();
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_data", 32'(rsp_data), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset rom_en", 32'(rom_en), 32'h0);
    check("reset rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;

    // Single request from requester 1.
    req_addr = {3'd0, 3'd0, 3'd5, 3'd0};
    req      = 4'b0010;
    serve("single", 1, 3'd5);

    // All four held from reset: served 0,1,2,3 back to back.
    rst = 1'b1;
    tick();
    req_addr = {3'd4, 3'd5, 3'd6, 3'd7};
    req      = 4'b1111;
    rst      = 1'b0;
    for (int k = 0; k < 4; k++) serve("all4", k, 3'(7 - k));

    // Fairness: serve 2 (ptr -> 3), then 0 and 3 together -> 3 first.
    req_addr = {3'd3, 3'd1, 3'd0, 3'd6};
    req      = 4'b0100;
    serve("fair r2", 2, 3'd1);
    req = 4'b1001;
    serve("fair r3", 3, 3'd3);
    serve("fair r0", 0, 3'd6);

    // Address change after grant is ignored.
    req_addr = {3'd0, 3'd0, 3'd0, 3'd2};
    req      = 4'b0001;
    tick();
    check("addrchg gnt", 32'(gnt), 32'h1);
    check("addrchg rom_addr read", 32'(rom_addr), 32'h2);
    req_addr = {3'd0, 3'd0, 3'd0, 3'd6};
    tick();
    check("addrchg rom_addr data", 32'(rom_addr), 32'h2);
    tick();
    check("addrchg rsp_valid", 32'(rsp_valid), 32'h1);
    check("addrchg rsp_data", 32'(rsp_data), 32'h2);
    req = '0;
    tick();
    check("addrchg busy idle", 32'(busy), 32'h0);

    // Asynchronous reset mid-DATA, request kept high.
    req_addr = {3'd5, 3'd0, 3'd0, 3'd0};
    req      = 4'b1000;
    tick();
    check("rstmid gnt", 32'(gnt), 32'h8);
    tick();
    check("rstmid busy data", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid async busy", 32'(busy), 32'h0);
    check("rstmid async rom_addr", 32'(rom_addr), 32'h0);
    check_quiet("rstmid async", 8'd0);
    tick();
    check("rstmid held rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    rst = 1'b0;
    serve("rstmid retry", 3, 3'd5);

    // Quiet period: nothing moves, rsp_data holds.
    for (int c = 0; c < 20; c++) begin
      tick();
      check_quiet("idle20", 8'd5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
